uart_loader: RTL and testbench
==============================

// Module: uart_loader
// PURPOSE
// - Boot-time bus initiator: receives a program image over UART and writes it into ram
//   over the same memwrite/addr/wd port the ktc32 core drives.
// - Holds the core in reset while loading; top muxes ram's port to the loader while busy=1.
// - Releases core reset once the image is written and validated.
// PARAMETERS
// - CLKS_PER_BIT  104     clk cycles per UART bit (12 MHz / 115200 baud)
// - BASE_ADDR     32'h0   byte address of the first word written
// - MAX_WORDS     4096    largest accepted image length, in 32-bit words
// PORTS
// - clk         in   1   system clock; all logic on the rising edge
// - n_reset     in   1   synchronous active-low reset
// - uart_rx     in   1   serial input, idle high, 8N1, LSB first
// - memwrite    out  2   00 none, 01 byte, 10 halfword, 11 word; loader drives only 00/11
// - addr        out  32  byte address of the write
// - wd          out  32  write data
// - busy        out  1   1 = loader owns the ram port
// - core_reset  out  1   active-high reset to ktc32
// - error       out  1   sticky load failure
// BEHAVIOUR
// - Reset (n_reset=0 at an edge): memwrite=00, addr=BASE_ADDR, wd=0, busy=1, core_reset=1,
//   error=0; FSM to LEN; byte/word counters to 0. Mid-load reset aborts with no further writes.
// - RX path
//   - uart_rx passes through a 2-flop synchronizer.
//   - Start detect: high->low transition on the synchronized line. Start bit re-sampled at
//     CLKS_PER_BIT/2; if high, it is a glitch: return to idle, no byte.
//   - 8 data bits then the stop bit, each sampled CLKS_PER_BIT after the previous sample.
//   - Stop bit low = framing error -> ERROR.
//   - byte_valid pulses 1 cycle at the stop-bit sample; the next start bit is accepted immediately.
// - Stream: 4-byte length N (words, little-endian), then 4*N data bytes (each word little-endian).
// - FSM states
//   - LEN: collect 4 bytes. N==0 or N>MAX_WORDS -> ERROR, otherwise -> DATA.
//   - DATA: assemble a word; on its 4th byte -> WRITE.
//   - WRITE: exactly 1 cycle, the cycle after the 4th byte_valid.
//     memwrite=11, addr=BASE_ADDR+4*i, wd=word. i increments.
//     i==N -> CHK (macro on) or DONE; otherwise -> DATA.
//   - DONE: busy=0, core_reset=0 from the next cycle. Further RX ignored. Exit by reset only.
//   - ERROR: error=1, busy=1, core_reset=1, memwrite=00. Exit by reset only.
// - memwrite=00 in every state except WRITE. addr/wd hold their last values outside WRITE.
// - Address arithmetic is 32-bit modulo 2^32; no bounds check beyond MAX_WORDS.
// CONFIGURATION
// - LOADER_CHECKSUM_EN defined:
//   - Running XOR of all data bytes (not the length bytes), cleared at reset.
//   - After the last WRITE, CHK waits for one byte.
//   - Match -> DONE; mismatch -> ERROR (all N writes have already been issued).
// - Undefined: no CHK state; the last WRITE goes straight to DONE.
// TESTING
// - T1: N=2, words 0x11223344, 0xAABBCCDD
//   -> 1-cycle writes (11, 0x0, 0x11223344), then (11, 0x4, 0xAABBCCDD).
//   -> busy and core_reset fall the cycle after the 2nd write (macro off).
// - T2: length bytes 00 00 00 00 -> error=1, core_reset=1, no write cycle.
// - T3: stop bit of data byte 3 driven low -> error=1 and no write issued.
//   A 0.3-bit low glitch on an idle line -> no byte, no error.
// - T4 (macro on): N=1, word 0x01020304
//   -> checksum byte 0x04 gives DONE; checksum byte 0x05 gives error=1 after the write at 0x0.
// - T5: n_reset low after 2 data bytes
//   -> all outputs at reset values next edge; a full N=1 reload writes BASE_ADDR.
// - T6: 8 bytes sent with zero idle gap between frames, N=1 -> correct single write, no error.

Source files
------------

// File: rtl/uart_loader.sv
// Boot loader: receives a length-prefixed program image over an 8N1 UART and writes it to ram,
// holding the core in reset until done. Define LOADER_CHECKSUM_EN to require a trailing XOR byte.
module uart_loader #(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          MAX_WORDS    = 4096
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        uart_rx,
    output logic [1:0]  memwrite,
    output logic [31:0] addr,
    output logic [31:0] wd,
    output logic        busy,
    output logic        core_reset,
    output logic        error
);

    localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERROR} state_t;

    rx_state_t     rx_state, rx_next;
    logic          rx_s1, rx_s2, rx_s3;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_shift;
    logic          sample, byte_valid, frame_err;

    state_t        state, state_next;
    logic [23:0]   acc;
    logic [31:0]   assembled;
    logic [1:0]    byte_cnt;
    logic [31:0]   len;
    logic [31:0]   word_idx;
    logic [31:0]   next_idx;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    // rx_s3 is the previous synchronized sample, used for falling-edge start detection.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign sample     = ((rx_state == RX_START) && (cnt == HALF)) ||
                        (((rx_state == RX_DATA) || (rx_state == RX_STOP)) && (cnt == FULL));
    assign byte_valid = (rx_state == RX_STOP) && sample && rx_s2;
    assign frame_err  = (rx_state == RX_STOP) && sample && !rx_s2;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_next;
            cnt      <= ((rx_state == RX_IDLE) || sample) ? '0 : cnt + 1'b1;
            if ((rx_state == RX_DATA) && sample) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                bit_idx  <= bit_idx + 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves rx_next unassigned (no latch).
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_s3 && !rx_s2) rx_next = RX_START;
            RX_START: if (sample) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (sample && (bit_idx == 3'd7)) rx_next = RX_STOP;
            RX_STOP:  if (sample) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Bytes arrive LSB-first, so shifting each new byte in at the top yields little-endian words.
    assign assembled = {rx_shift, acc};
    assign next_idx  = word_idx + 32'd1;

    always_ff @(posedge clk) begin
        if (!n_reset) state <= S_LEN;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_LEN:
                if (byte_valid && (byte_cnt == 2'd3)) begin
                    if ((assembled == 32'd0) || (assembled > 32'(MAX_WORDS))) state_next = S_ERROR;
                    else                                                      state_next = S_DATA;
                end
            S_DATA:
                if (byte_valid && (byte_cnt == 2'd3)) state_next = S_WRITE;
            S_WRITE:
`ifdef LOADER_CHECKSUM_EN
                state_next = (next_idx == len) ? S_CHK : S_DATA;
            S_CHK:
                if (byte_valid) state_next = (rx_shift == csum) ? S_DONE : S_ERROR;
`else
                state_next = (next_idx == len) ? S_DONE : S_DATA;
`endif
            default: state_next = state;
        endcase
        if (frame_err && (state != S_DONE) && (state != S_ERROR)) state_next = S_ERROR;
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            acc      <= '0;
            byte_cnt <= '0;
            len      <= '0;
            word_idx <= '0;
            addr     <= BASE_ADDR;
            wd       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            if (byte_valid && ((state == S_LEN) || (state == S_DATA))) begin
                acc      <= assembled[31:8];
                byte_cnt <= byte_cnt + 1'b1;
            end
            if ((state == S_LEN) && byte_valid && (byte_cnt == 2'd3))
                len <= assembled;
            // addr/wd are loaded on entry to WRITE and hold afterwards.
            if ((state == S_DATA) && byte_valid && (byte_cnt == 2'd3)) begin
                wd   <= assembled;
                addr <= BASE_ADDR + {word_idx[29:0], 2'b00};
            end
            if (state == S_WRITE)
                word_idx <= next_idx;
`ifdef LOADER_CHECKSUM_EN
            if ((state == S_DATA) && byte_valid)
                csum <= csum ^ rx_shift;
`endif
        end
    end

    assign memwrite   = (state == S_WRITE) ? 2'b11 : 2'b00;
    assign busy       = (state != S_DONE);
    assign core_reset = (state != S_DONE);
    assign error      = (state == S_ERROR);

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: table of length-field cases plus hand-written load sequences.
module tb_uart_loader;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        uart_rx = 1'b1;
    logic [1:0]  memwrite;
    logic [31:0] addr, wd;
    logic        busy, core_reset, error;

    always #5 clk = ~clk;

    uart_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0), .MAX_WORDS(4096)) dut (
        .clk(clk), .n_reset(n_reset), .uart_rx(uart_rx), .memwrite(memwrite),
        .addr(addr), .wd(wd), .busy(busy), .core_reset(core_reset), .error(error)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] csum = 8'h00;

    // Write monitor, sampled on the falling edge.
    int cyc = 0, wr_cnt = 0, last_wr_cyc = 0, busy_fall_cyc = 0, bad_mw = 0;
    logic busy_q = 1'b1;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        busy_q <= busy;
        if (busy_q && !busy) busy_fall_cyc <= cyc;
        if (memwrite != 2'b00) begin
            if (memwrite != 2'b11) bad_mw <= bad_mw + 1;
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] <= addr;
                wr_data[wr_cnt] <= wd;
            end
            wr_cnt      <= wr_cnt + 1;
            last_wr_cyc <= cyc;
        end
    end

    typedef struct {
        string       name;
        logic [31:0] len;
        logic        exp_err;
    } len_vec_t;

    len_vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0;
        uart_rx = 1'b1;
        csum    = 8'h00;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_len(input logic [31:0] n, input int gap);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b1, gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            csum = csum ^ w[8*i +: 8];
            send_byte(w[8*i +: 8], 1'b1, gap);
        end
    endtask

    task automatic send_csum(input int gap);
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum, 1'b1, gap);
`else
        repeat (gap) @(negedge clk);
`endif
    endtask

    task automatic settle();
        repeat (4 * CPB) @(negedge clk);
    endtask

    initial begin
        int base;

        vecs[0] = '{name: "len_zero",     len: 32'd0,          exp_err: 1'b1};
        vecs[1] = '{name: "len_over_max", len: 32'd4097,       exp_err: 1'b1};
        vecs[2] = '{name: "len_all_ones", len: 32'hFFFF_FFFF,  exp_err: 1'b1};
        vecs[3] = '{name: "len_one",      len: 32'd1,          exp_err: 1'b0};
        vecs[4] = '{name: "len_max",      len: 32'd4096,       exp_err: 1'b0};

        do_reset();
        check("rst_memwrite",   32'(memwrite),   32'd0);
        check("rst_addr",       addr,            32'h0);
        check("rst_wd",         wd,              32'h0);
        check("rst_busy",       32'(busy),       32'd1);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_error",      32'(error),      32'd0);

        // Length field validation
        for (int i = 0; i < 5; i++) begin
            do_reset();
            base = wr_cnt;
            send_len(vecs[i].len, 2);
            settle();
            check({vecs[i].name, "_error"},      32'(error),      32'(vecs[i].exp_err));
            check({vecs[i].name, "_busy"},       32'(busy),       32'd1);
            check({vecs[i].name, "_core_reset"}, 32'(core_reset), 32'd1);
            check({vecs[i].name, "_writes"},     32'(wr_cnt - base), 32'd0);
        end

        // Two-word image
        do_reset();
        base = wr_cnt;
        send_len(32'd2, 2);
        send_word(32'h1122_3344, 2);
        send_word(32'hAABB_CCDD, 2);
        send_csum(2);
        settle();
        check("t1_writes",     32'(wr_cnt - base), 32'd2);
        check("t1_addr0",      wr_addr[base],      32'h0);
        check("t1_data0",      wr_data[base],      32'h1122_3344);
        check("t1_addr1",      wr_addr[base + 1],  32'h4);
        check("t1_data1",      wr_data[base + 1],  32'hAABB_CCDD);
        check("t1_busy",       32'(busy),          32'd0);
        check("t1_core_reset", 32'(core_reset),    32'd0);
        check("t1_error",      32'(error),         32'd0);
`ifndef LOADER_CHECKSUM_EN
        check("t1_release_cycle", 32'(busy_fall_cyc), 32'(last_wr_cyc + 1));
`endif

        // Short low glitch on an idle line must not produce a byte
        do_reset();
        base = wr_cnt;
        uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("t3_glitch_error", 32'(error), 32'd0);
        send_len(32'd1, 2);
        send_word(32'h5A5A_A5A5, 2);
        send_csum(2);
        settle();
        check("t3_glitch_writes", 32'(wr_cnt - base), 32'd1);
        check("t3_glitch_data",   wr_data[base],      32'h5A5A_A5A5);
        check("t3_glitch_busy",   32'(busy),          32'd0);

        // Framing error on the third data byte
        do_reset();
        base = wr_cnt;
        send_len(32'd1, 2);
        send_byte(8'h01, 1'b1, 2);
        send_byte(8'h02, 1'b1, 2);
        send_byte(8'h03, 1'b0, 2);
        settle();
        check("t3_frame_error",      32'(error),      32'd1);
        check("t3_frame_core_reset", 32'(core_reset), 32'd1);
        check("t3_frame_busy",       32'(busy),       32'd1);
        send_byte(8'h04, 1'b1, 2);
        settle();
        check("t3_frame_writes",     32'(wr_cnt - base), 32'd0);
        check("t3_frame_sticky",     32'(error),         32'd1);

        // Reset in the middle of a load, then a clean reload
        do_reset();
        base = wr_cnt;
        send_len(32'd3, 2);
        send_word(32'h1234_5678, 2);
        send_word(32'h9ABC_DEF0, 2);
        send_byte(8'hEE, 1'b1, 2);
        send_byte(8'hFF, 1'b1, 2);
        check("t5_pre_writes", 32'(wr_cnt - base), 32'd2);
        check("t5_pre_addr",   addr,               32'h4);
        n_reset = 1'b0;
        @(posedge clk);
        #1;
        check("t5_rst_memwrite",   32'(memwrite),   32'd0);
        check("t5_rst_addr",       addr,            32'h0);
        check("t5_rst_wd",         wd,              32'h0);
        check("t5_rst_busy",       32'(busy),       32'd1);
        check("t5_rst_core_reset", 32'(core_reset), 32'd1);
        check("t5_rst_error",      32'(error),      32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        csum    = 8'h00;
        @(negedge clk);
        base = wr_cnt;
        send_len(32'd1, 2);
        send_word(32'hCAFE_F00D, 2);
        send_csum(2);
        settle();
        check("t5_reload_writes", 32'(wr_cnt - base), 32'd1);
        check("t5_reload_addr",   wr_addr[base],      32'h0);
        check("t5_reload_data",   wr_data[base],      32'hCAFE_F00D);
        check("t5_reload_busy",   32'(busy),          32'd0);

        // Back-to-back frames with no idle gap
        do_reset();
        base = wr_cnt;
        send_len(32'd1, 0);
        send_word(32'h0BAD_BEEF, 0);
        send_csum(0);
        settle();
        check("t6_writes", 32'(wr_cnt - base), 32'd1);
        check("t6_addr",   wr_addr[base],      32'h0);
        check("t6_data",   wr_data[base],      32'h0BAD_BEEF);
        check("t6_error",  32'(error),         32'd0);
        check("t6_busy",   32'(busy),          32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum byte matching / not matching the XOR of data bytes (04^03^02^01 = 04)
        do_reset();
        base = wr_cnt;
        send_len(32'd1, 2);
        send_word(32'h0102_0304, 2);
        send_byte(8'h04, 1'b1, 2);
        settle();
        check("t4_good_writes", 32'(wr_cnt - base), 32'd1);
        check("t4_good_data",   wr_data[base],      32'h0102_0304);
        check("t4_good_error",  32'(error),         32'd0);
        check("t4_good_busy",   32'(busy),          32'd0);

        do_reset();
        base = wr_cnt;
        send_len(32'd1, 2);
        send_word(32'h0102_0304, 2);
        send_byte(8'h05, 1'b1, 2);
        settle();
        check("t4_bad_writes", 32'(wr_cnt - base), 32'd1);
        check("t4_bad_addr",   wr_addr[base],      32'h0);
        check("t4_bad_error",  32'(error),         32'd1);
        check("t4_bad_busy",   32'(busy),          32'd1);
`endif

        check("memwrite_codes", 32'(bad_mw), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
